bram_port_arbiter: RTL
======================

// Module: bram_port_arbiter
// PURPOSE
//  Two-requester arbiter for the single 128-bit cache-line BRAM port shared by the
//  instruction-side and data-side UA_encrypt units. Replaces the ad-hoc arbitration
//  block that sits between them and bram_memory.
//  - Data side has fixed priority, with a starvation bound for the instruction side.
//  - Grant is held for a whole transaction; read data and ready are registered per requester.
// PARAMETERS
//  ADDR_BITS   15   BRAM line-address width (matches BRAM_ADDR_BITS)
//  DATA_WIDTH  128  line width in bits
//  MAX_STARVE  4    consecutive data grants allowed while inst is pending; min 1
// PORTS
//  HCLK        in   1           system clock
//  HRESETn     in   1           asynchronous active-low reset
//  d_req       in   1           data requester: request, held until d_rdy
//  d_write     in   1           data requester: 1=write, 0=read
//  d_addr      in   ADDR_BITS   data requester: line address
//  d_wdata     in   DATA_WIDTH  data requester: write line
//  d_rdata     out  DATA_WIDTH  data requester: read line, valid with d_rdy
//  d_rdy       out  1           data requester: one-cycle completion pulse
//  i_req, i_write, i_addr, i_wdata, i_rdata, i_rdy   same as d_*, instruction side
//  mem_req     out  1           to BRAM, held high for the active transaction
//  mem_write   out  1           to BRAM: write enable
//  mem_addr    out  ADDR_BITS   to BRAM: line address
//  mem_wdata   out  DATA_WIDTH  to BRAM: write line
//  mem_rdata   in   DATA_WIDTH  from BRAM: read line, sampled on mem_valid
//  mem_valid   in   1           from BRAM: one-cycle completion pulse
//  grant_inst  out  1           status: 1 while an inst transaction is active
// BEHAVIOUR
//  Reset: state IDLE; starve_cnt=0.
//   All outputs 0: mem_*, d_rdy, i_rdy, d_rdata, i_rdata, grant_inst.
//  All outputs are registered. States: IDLE, BUSY, RESP, GAP.
//  IDLE: sample requests each cycle.
//   - Pick inst if i_req && (!d_req || starve_cnt==MAX_STARVE); else pick data if d_req.
//   - On a pick: latch that requester's write/addr/wdata into mem_* and set mem_req=1.
//     Set grant_inst=(pick==inst). Go to BUSY.
//   - Nothing requested: stay in IDLE with mem_req=0.
//  starve_cnt update, at each pick:
//   - data picked while i_req=1 -> starve_cnt+1, saturating at MAX_STARVE;
//   - inst picked -> starve_cnt=0;
//   - data picked while i_req=0 -> starve_cnt=0.
//  BUSY: hold mem_* stable.
//   - On mem_valid: mem_req=0. On reads, latch mem_rdata into the granted requester's
//     rdata register; on writes, rdata is unchanged. Go to RESP.
//  RESP: granted requester's rdy=1 for exactly one cycle; the other rdy stays 0.
//   grant_inst cleared. Go to GAP.
//  GAP: one dead cycle with no sampling, so the requester can drop req. Go to IDLE.
//  Latency: req seen in IDLE at cycle t -> mem_req at t+1 -> mem_valid at t+1+L
//   -> rdy at t+2+L. Back-to-back transactions are spaced at least L+4 cycles apart.
//  Simultaneous d_req and i_req in IDLE: data wins unless starve_cnt==MAX_STARVE.
//  A request dropped while not granted is forgotten; no state is kept.
//  A request dropped mid-transaction is ignored: the transaction completes and rdy still pulses.
//  mem_valid outside BUSY is ignored.
//  rdata registers hold their value until the next read for that requester.
//  Reset asserted mid-transaction: immediate return to reset values; the BRAM op is abandoned.
//  No timeout: a missing mem_valid stalls the arbiter in BUSY (debug via grant_inst).
// TESTING
//  1 Data read only: d_req=1, d_addr=0x0010, BRAM L=1, returns 0xA5..A5
//    -> mem_req rises 1 cycle after d_req; d_rdy pulses once 3 cycles after d_req;
//       d_rdata=0xA5..A5; i_rdy stays 0.
//  2 Inst write: i_req=1, i_write=1, i_addr=0x7FFF (max), i_wdata=pattern
//    -> BRAM line 0x7FFF is written; i_rdy pulses once; i_rdata is unchanged.
//  3 Simultaneous d_req and i_req from IDLE with starve_cnt=0
//    -> data is served first, then inst; the two rdy pulses never overlap.
//  4 Starvation: d_req held high with new requests every GAP, i_req held high, MAX_STARVE=4
//    -> exactly 4 data grants, then 1 inst grant, then data again.
//  5 Reset deasserted-then-asserted while in BUSY
//    -> all outputs are 0 in the same cycle as reset;
//       after release, a new d_req completes normally.
//  6 Spurious mem_valid in IDLE, then a requester drops req before being granted
//    -> no rdy pulse; no mem_req.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two requester ports and the BRAM port around bram_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters/BRAM.
interface bram_port_arbiter_if #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_WIDTH = 128
);
  logic                  d_req;
  logic                  d_write;
  logic [ADDR_BITS-1:0]  d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_rdy;

  logic                  i_req;
  logic                  i_write;
  logic [ADDR_BITS-1:0]  i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_rdy;

  logic                  mem_req;
  logic                  mem_write;
  logic [ADDR_BITS-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_valid;

  logic                  grant_inst;

  modport slave (
    input  d_req, d_write, d_addr, d_wdata,
    input  i_req, i_write, i_addr, i_wdata,
    input  mem_rdata, mem_valid,
    output d_rdata, d_rdy, i_rdata, i_rdy,
    output mem_req, mem_write, mem_addr, mem_wdata,
    output grant_inst
  );

  modport master (
    output d_req, d_write, d_addr, d_wdata,
    output i_req, i_write, i_addr, i_wdata,
    output mem_rdata, mem_valid,
    input  d_rdata, d_rdy, i_rdata, i_rdy,
    input  mem_req, mem_write, mem_addr, mem_wdata,
    input  grant_inst
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbitrates the shared cache-line BRAM port between data-side and instruction-side
// requesters: data has fixed priority, inst is guaranteed a grant after MAX_STARVE data wins.
module bram_port_arbiter #(
  parameter int ADDR_BITS  = 15,
  parameter int DATA_WIDTH = 128,
  parameter int MAX_STARVE = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  bram_port_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  mem_req_r;
  logic                  mem_write_r;
  logic [ADDR_BITS-1:0]  mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [DATA_WIDTH-1:0] d_rdata_r;
  logic [DATA_WIDTH-1:0] i_rdata_r;
  logic                  d_rdy_r;
  logic                  i_rdy_r;
  logic                  grant_inst_r;
  logic                  pick_inst;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(MAX_STARVE)) ? v : v + 1'b1;
  endfunction

  // Inst only beats a pending data request once data has won MAX_STARVE times in a row.
  assign pick_inst = bus.i_req && (!bus.d_req || (starve_cnt == CNT_W'(MAX_STARVE)));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      mem_req_r    <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      d_rdata_r    <= '0;
      i_rdata_r    <= '0;
      d_rdy_r      <= 1'b0;
      i_rdy_r      <= 1'b0;
      grant_inst_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            mem_req_r    <= 1'b1;
            grant_inst_r <= pick_inst;
            state        <= BUSY;
            if (pick_inst) begin
              mem_write_r <= bus.i_write;
              mem_addr_r  <= bus.i_addr;
              mem_wdata_r <= bus.i_wdata;
              starve_cnt  <= '0;
            end else begin
              mem_write_r <= bus.d_write;
              mem_addr_r  <= bus.d_addr;
              mem_wdata_r <= bus.d_wdata;
              starve_cnt  <= bus.i_req ? sat_inc(starve_cnt) : '0;
            end
          end
        end
        BUSY: begin
          // rdy is raised here so it is visible during RESP, alongside the latched line.
          if (bus.mem_valid) begin
            mem_req_r <= 1'b0;
            if (!mem_write_r) begin
              if (grant_inst_r) i_rdata_r <= bus.mem_rdata;
              else              d_rdata_r <= bus.mem_rdata;
            end
            if (grant_inst_r) i_rdy_r <= 1'b1;
            else              d_rdy_r <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          d_rdy_r      <= 1'b0;
          i_rdy_r      <= 1'b0;
          grant_inst_r <= 1'b0;
          state        <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_write  = mem_write_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign bus.d_rdata    = d_rdata_r;
  assign bus.i_rdata    = i_rdata_r;
  assign bus.d_rdy      = d_rdy_r;
  assign bus.i_rdy      = i_rdy_r;
  assign bus.grant_inst = grant_inst_r;

endmodule
